program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//   Instruction-supply side of the Nibbler fetch interface. Owns the 12-bit program counter
//   and reads the 4K x 8 program ROM through a req/valid handshake. Presents each byte on
//   programByte with a one-cycle phase strobe, which the fetch stage latches into instr/operand.
//   It then opens an execute slot in which the core may redirect the PC (jump) or halt.
// PARAMETERS
//   ADDR_W      12   program counter / ROM address width; PC wraps modulo 2**ADDR_W
//   DATA_W      8    ROM word width = {instr[3:0], operand[3:0]}
//   TIMEOUT     15   max cycles rom_req may stay high without rom_valid before fault
// PORTS
//   clk          in   1       sole clock, all state updates on posedge
//   reset        in   1       synchronous, active-high; clears all state
//   rom_req      out  1       read request to program ROM
//   rom_addr     out  ADDR_W  ROM address, stable while rom_req=1
//   rom_data     in   DATA_W  ROM read data, sampled only when rom_valid=1 and rom_req=1
//   rom_valid    in   1       ROM read complete; ignored when rom_req=0
//   programByte  out  DATA_W  registered instruction byte to fetch stage
//   phase        out  1       1 for exactly one cycle per instruction: fetch stage latch strobe
//   jump_en      in   1       core requests PC redirect; sampled in EXEC only
//   jump_addr    in   ADDR_W  redirect target; sampled with jump_en
//   halt         in   1       core halt request; sampled in EXEC only
//   pc           out  ADDR_W  address of the instruction currently presented/executing
//   halted       out  1       sticky, set on entry to HALT
//   fault        out  1       sticky, set on ROM timeout
// BEHAVIOUR
//   Reset (posedge with reset=1, any state): state=IDLE, pc=0, rom_req=0, rom_addr=0,
//     programByte=0, phase=0, halted=0, fault=0, timeout count=0. An in-flight ROM read is abandoned.
//     A rom_valid arriving after reset is ignored.
//   FSM: IDLE -> REQ (unconditionally, one cycle after reset release)
//     REQ:   rom_req=1, rom_addr=pc. If rom_valid: programByte<=rom_data, rom_req<=0, -> FETCH.
//            Otherwise count++. When count reaches TIMEOUT: rom_req<=0, fault<=1, -> FAULT.
//     FETCH: phase=1 for this single cycle; programByte stable. -> EXEC.
//     EXEC:  phase=0. Priority: halt > jump_en > increment.
//            halt=1 -> halted<=1, pc unchanged, -> HALT.
//            jump_en=1 -> pc<=jump_addr, -> REQ.
//            else pc<=pc+1 (4095 wraps to 0, no flag), -> REQ.
//     HALT, FAULT: terminal. Outputs hold, rom_req=0, phase=0; exit only via reset.
//   Timing: with a zero-wait ROM (rom_valid in the first REQ cycle), one instruction takes
//     3 cycles (REQ, FETCH, EXEC). Each ROM wait cycle adds 1 cycle.
//   Timeout count clears on every entry to REQ.
//   programByte changes only on a REQ capture. It holds through FETCH, EXEC and terminal states.
//   phase and programByte are both registered, so the fetch stage sees them aligned at one edge.
//   jump_en and halt outside EXEC have no effect. rom_req never drops before rom_valid,
//     except on timeout or reset.
// STRUCTURE
//   nibbler_pkg:
//     - ADDR_W/DATA_W defaults
//     - seq_state_t enum {IDLE, REQ, FETCH, EXEC, HALT, FAULT}
//     - TIMEOUT default constant
//   Sub-module nibbler_pc: ADDR_W register with sync clear, load (jump) and wrap-around
//     increment, and a hold when neither is active. All other logic sits inline in program_sequencer.
// TESTING
//   1 Reset, then zero-wait ROM holding 0x3A at addr 0 -> rom_req rises 1 cycle after
//     reset release, phase=1 with programByte=0x3A 1 cycle later, pc=0, then pc=1.
//   2 ROM with 2 wait cycles -> rom_addr stable for 3 cycles of rom_req.
//     phase pulses exactly once per instruction; period = 5 cycles.
//   3 jump_en=1, jump_addr=0x7F0 in EXEC -> next rom_addr=0x7F0.
//     jump_en asserted in FETCH only -> ignored, pc increments.
//   4 pc=0xFFF, no jump -> next rom_addr=0x000, no fault.
//   5 halt and jump_en both 1 in EXEC -> halted=1, pc unchanged, rom_req stays 0.
//     reset then restarts at pc=0.
//   6 rom_valid never asserted -> after TIMEOUT=15 REQ cycles, rom_req=0 and fault=1.
//     reset during a pending REQ -> rom_req=0 on the next cycle, and a late rom_valid is ignored.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types and default sizes for the Nibbler instruction-supply path.
package nibbler_pkg;

  localparam int NIB_ADDR_W  = 12;  // program counter / ROM address width
  localparam int NIB_DATA_W  = 8;   // ROM word: {instr[3:0], operand[3:0]}
  localparam int NIB_TIMEOUT = 15;  // max rom_req cycles without rom_valid

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FETCH,
    EXEC,
    HALT,
    FAULT
  } seq_state_t;

endpackage : nibbler_pkg

// File: rtl/nibbler_pc.sv
// Program counter register: synchronous clear, load for jumps, and an
// increment that wraps modulo 2**W. It holds when neither load nor inc is set.
module nibbler_pc
  import nibbler_pkg::*;
#(
  parameter int W = NIB_ADDR_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_addr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  // PC update: clear wins, then load, then increment; otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;  // the carry out of the top bit is dropped, so 4095 wraps to 0
    end
  end

endmodule : nibbler_pc

// File: rtl/program_sequencer.sv
// Instruction-supply side of the Nibbler fetch interface. It reads one ROM byte
// per instruction through a req/valid handshake and presents it on programByte
// with a single-cycle phase strobe. It then opens an EXEC slot, where the core
// can jump or halt. A ROM that never answers puts the block into FAULT.
module program_sequencer
  import nibbler_pkg::*;
#(
  parameter int ADDR_W  = NIB_ADDR_W,
  parameter int DATA_W  = NIB_DATA_W,
  parameter int TIMEOUT = NIB_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  output logic [DATA_W-1:0] programByte,
  output logic              phase,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value seen in the last allowed REQ cycle: TIMEOUT cycles in REQ in total.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             exec_go;
  logic             pc_load;
  logic             pc_inc;

  // The PC moves only in EXEC, and only if the core is not halting.
  // A halt takes priority over a jump, and a jump takes priority over the increment.
  assign exec_go = (state == EXEC) && !halt;
  assign pc_load = exec_go && jump_en;
  assign pc_inc  = exec_go && !jump_en;

  nibbler_pc #(
    .W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .clear     (reset),
    .load      (pc_load),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // The PC register is frozen for the whole REQ state, so it doubles as the stable ROM address.
  assign rom_addr = pc;

  // Sequencer FSM with registered handshake, strobe and sticky status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rom_req     <= 1'b0;
      programByte <= '0;
      phase       <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      // NOTE: registers not assigned on a given path simply hold; inside
      // always_ff that is a flop enable, not an inferred latch.
      case (state)
        IDLE: begin
          rom_req <= 1'b1;
          tmo_cnt <= '0;
          state   <= REQ;
        end

        REQ: begin
          if (rom_valid && rom_req) begin
            programByte <= rom_data;
            rom_req     <= 1'b0;
            phase       <= 1'b1;
            state       <= FETCH;
          end else if (tmo_cnt == TMO_LAST) begin
            rom_req <= 1'b0;
            fault   <= 1'b1;
            state   <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        FETCH: begin
          // phase was raised on entry; it drops after exactly one cycle.
          phase <= 1'b0;
          state <= EXEC;
        end

        EXEC: begin
          if (halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            // The PC updates on this same edge, so the next request uses the new address.
            rom_req <= 1'b1;
            tmo_cnt <= '0;
            state   <= REQ;
          end
        end

        // HALT and FAULT are terminal: all outputs hold until reset.
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule : program_sequencer

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer. A behavioural ROM with a
// programmable wait count answers requests. The test thread acts as the core,
// and a scoreboard checks every phase strobe against the expected {pc, byte}.
module tb_program_sequencer;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_valid;
  logic [DW-1:0] programByte;
  logic          phase;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fault;

  program_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_valid   (rom_valid),
    .programByte (programByte),
    .phase       (phase),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROM contents and model.
  logic [DW-1:0] mem [4096];
  int            rom_wait  = 0;   // wait cycles before rom_valid
  bit            rom_force = 1'b0; // drive a stray rom_valid while rom_req is low
  int            rom_cnt;
  logic [AW-1:0] rom_first;

  initial begin
    rom_valid = 1'b0;
    rom_data  = '0;
    rom_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rom_req === 1'b1) begin
        if (rom_cnt == 0) rom_first = rom_addr;
        else check("rom_addr_stable", rom_addr, rom_first);
        if (rom_cnt >= rom_wait) begin
          rom_valid = 1'b1;
          rom_data  = mem[rom_addr];
        end else begin
          rom_valid = 1'b0;
        end
        rom_cnt++;
      end else begin
        rom_cnt   = 0;
        rom_valid = rom_force;
        rom_data  = rom_force ? 8'hEE : 8'h00;
      end
    end
  end

  // Scoreboard: expected {pc, byte} for each phase strobe.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] b;
  } exp_t;

  exp_t exp_q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (phase === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_phase", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", pc, e.pc);
          check("sb_byte", programByte, e.b);
        end
      end
    end
  end

  logic [AW-1:0] m_pc;  // model program counter

  // Wait, with a bound, for the negedge that shows phase=1; cyc counts the negedges.
  task automatic wait_phase(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (phase !== 1'b1 && cyc < 60);
    if (phase !== 1'b1) check("phase_timeout", 0, 1);
  endtask

  // One instruction: expect the fetch of m_pc, then drive the core command.
  // in_fetch=1 presents the command during FETCH only, where it must be ignored.
  task automatic run_instr(input logic j, input logic [AW-1:0] ja, input logic h,
                           input bit in_fetch, output int cyc);
    exp_q.push_back('{pc: m_pc, b: mem[m_pc]});
    wait_phase(cyc);
    if (in_fetch) begin
      jump_en = j; jump_addr = ja; halt = h;
    end
    @(negedge clk);  // EXEC cycle
    check("phase_one_cycle", phase, 0);
    if (in_fetch) begin
      jump_en = 1'b0; halt = 1'b0;
    end else begin
      jump_en = j; jump_addr = ja; halt = h;
    end
    @(negedge clk);  // first cycle after EXEC
    jump_en = 1'b0;
    halt    = 1'b0;
    if (h && !in_fetch) begin
      check("halt_flag", halted, 1);
      check("halt_req_low", rom_req, 0);
      check("halt_pc_hold", pc, m_pc);
    end else begin
      m_pc = (j && !in_fetch) ? ja : m_pc + 12'd1;
      check("next_req", rom_req, 1);
      check("next_addr", rom_addr, m_pc);
      check("no_fault", fault, 0);
    end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            cyc;
    int            n;
    logic [DW-1:0] last_byte;

    foreach (mem[i]) mem[i] = DW'($urandom);
    mem[0] = 8'h3A;

    reset = 1'b1; jump_en = 1'b0; jump_addr = '0; halt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", rom_req, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_pc", pc, 0);
    check("rst_byte", programByte, 0);
    check("rst_phase", phase, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);

    // 1: zero-wait ROM. rom_req rises one cycle after release, and phase follows one cycle later.
    reset = 1'b0;
    @(negedge clk);
    check("t1_req_rise", rom_req, 1);
    check("t1_addr", rom_addr, 0);
    m_pc = '0;
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    check("t1_phase_lat", cyc, 1);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);

    // 2: two ROM wait cycles make rom_req last 3 cycles and the instruction period 5 cycles.
    // The request already in flight was answered with zero wait.
    rom_wait = 2;
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    check("t2_req_cycles", cyc, 3);
    check("t2_period", cyc + 2, 5);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    check("t2_period_b", cyc + 2, 5);
    rom_wait = 0;

    // 3: a jump in EXEC is taken, and a jump shown only in FETCH is ignored.
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    run_instr(1'b1, 12'h7F0, 1'b0, 1'b0, cyc);
    run_instr(1'b1, 12'h123, 1'b0, 1'b1, cyc);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);

    // 4: the PC wraps from 0xFFF to 0x000 and no fault is raised.
    run_instr(1'b1, 12'hFFF, 1'b0, 1'b0, cyc);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    check("t4_wrap_addr", rom_addr, 12'h000);
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);

    // 5: halt and jump together make halt win. HALT is terminal until reset.
    last_byte = mem[m_pc];
    run_instr(1'b1, 12'h555, 1'b1, 1'b0, cyc);
    repeat (5) @(negedge clk);
    check("t5_req_low", rom_req, 0);
    check("t5_phase_low", phase, 0);
    check("t5_halted", halted, 1);
    check("t5_pc_hold", pc, m_pc);
    check("t5_byte_hold", programByte, last_byte);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_halted", halted, 0);
    check("t5_rst_pc", pc, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_restart_req", rom_req, 1);
    m_pc = '0;
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);

    // 6: a ROM that never answers times out after 15 REQ cycles.
    reset    = 1'b1;
    rom_wait = 100000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n = 0;
    while (rom_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t6_req_cycles", n, 15);
    check("t6_fault", fault, 1);
    check("t6_req_low", rom_req, 0);
    check("t6_not_halted", halted, 0);

    // 6b: a reset during a pending REQ drops rom_req, and a later stray rom_valid is ignored.
    reset    = 1'b1;
    @(negedge clk);
    check("t6_rst_fault", fault, 0);
    reset    = 1'b0;
    rom_wait = 3;
    @(negedge clk);
    check("t6_pending_req", rom_req, 1);
    reset     = 1'b1;
    rom_force = 1'b1;
    @(negedge clk);
    check("t6_rst_req_drop", rom_req, 0);
    @(negedge clk);
    check("t6_rst_byte", programByte, 0);
    check("t6_rst_phase", phase, 0);
    rom_wait = 0;
    reset    = 1'b0;
    @(negedge clk);
    rom_force = 1'b0;
    check("t6_late_req", rom_req, 1);
    check("t6_late_byte", programByte, 0);
    check("t6_late_phase", phase, 0);
    m_pc = '0;
    run_instr(1'b0, '0, 1'b0, 1'b0, cyc);
    check("t6_restart_lat", cyc, 1);
    run_instr(1'b0, '0, 1'b1, 1'b0, cyc);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_sequencer
